// File: rtl/damage_round_scheduler.sv
// ============================================================================
// Module   : damage_round_scheduler
// Brief    : Per-frame bullet-damage round controller and owner of player HP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module damage_round_scheduler #(
    parameter int MAX_HP        = 200,
    parameter int HEAL_AMOUNT   = 20,
    parameter int IFRAME_ROUNDS = 30,
    parameter int TIMEOUT       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic       calc_done,
    input  logic [7:0] calc_damage,
    input  logic       calc_heal,
    output logic       calc_start,
    output logic [7:0] hp,
    output logic       dead,
    output logic       invuln,
    output logic       busy,
    output logic       hit,
    output logic       healed,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int IW = $clog2(IFRAME_ROUNDS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    HP_FULL   = 8'(MAX_HP);
    localparam logic [9:0]    HP_CEIL   = 10'(MAX_HP);
    localparam logic [9:0]    HEAL_STEP = 10'(HEAL_AMOUNT);
    localparam logic [IW-1:0] IFR_LOAD  = IW'(IFRAME_ROUNDS);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_APPLY = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    state_t        state_q,   state_d;
    logic [7:0]    hp_q,      hp_d;
    logic [IW-1:0] ifr_q,     ifr_d;
    logic [WW-1:0] wait_q,    wait_d;
    logic [7:0]    dmg_q,     dmg_d;
    logic          heal_q,    heal_d;
    logic          hit_q,     hit_d;
    logic          healed_q,  healed_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;

    logic          busy_w;
    logic [7:0]    dmg_eff_w;
    logic [8:0]    hp_sub_w;
    logic [7:0]    hp_after_dmg_w;
    logic [9:0]    hp_heal_w;
    logic [7:0]    hp_after_heal_w;
    logic [WW-1:0] wait_inc_w;

    assign busy_w = (state_q == ST_START) || (state_q == ST_WAIT) || (state_q == ST_APPLY);

    // Damage arithmetic is done one bit wider so an underflow saturates instead of wrapping.
    always_comb begin
        dmg_eff_w       = (ifr_q != '0) ? 8'd0 : dmg_q;
        hp_sub_w        = {1'b0, hp_q} - {1'b0, dmg_eff_w};
        hp_after_dmg_w  = hp_sub_w[8] ? 8'd0 : hp_sub_w[7:0];
        hp_heal_w       = {2'b00, hp_after_dmg_w} + HEAL_STEP;
        hp_after_heal_w = (hp_heal_w > HP_CEIL) ? HP_FULL : hp_heal_w[7:0];
        wait_inc_w      = wait_q + WW'(1);
    end

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        ifr_d     = ifr_q;
        wait_d    = wait_q;
        dmg_d     = dmg_q;
        heal_d    = heal_q;
        hit_d     = 1'b0;
        healed_d  = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;

        if (restart) begin
            state_d = ST_IDLE;
            hp_d    = HP_FULL;
            ifr_d   = '0;
            wait_d  = '0;
        end else begin
            if (frame_tick && busy_w) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_tick && enable) begin
                        state_d = ST_START;
                    end
                end

                ST_START: begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end

                // A completion sampled on the expiry edge still wins over the timeout.
                ST_WAIT: begin
                    if (calc_done) begin
                        dmg_d   = calc_damage;
                        heal_d  = calc_heal;
                        state_d = ST_APPLY;
                    end else begin
                        wait_d = wait_inc_w;
                        if (wait_inc_w == WAIT_MAX) begin
                            timeout_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end

                ST_APPLY: begin
                    if (dmg_eff_w != 8'd0) begin
                        hit_d = 1'b1;
                        ifr_d = IFR_LOAD;
                    end else if (ifr_q != '0) begin
                        ifr_d = ifr_q - IW'(1);
                    end

                    if (hp_after_dmg_w == 8'd0) begin
                        hp_d    = 8'd0;
                        state_d = ST_DEAD;
                    end else if (heal_q) begin
                        hp_d     = hp_after_heal_w;
                        healed_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        hp_d    = hp_after_dmg_w;
                        state_d = ST_IDLE;
                    end
                end

                ST_DEAD: begin
                    state_d = ST_DEAD;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hp_q      <= HP_FULL;
            ifr_q     <= '0;
            wait_q    <= '0;
            dmg_q     <= 8'd0;
            heal_q    <= 1'b0;
            hit_q     <= 1'b0;
            healed_q  <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            ifr_q     <= ifr_d;
            wait_q    <= wait_d;
            dmg_q     <= dmg_d;
            heal_q    <= heal_d;
            hit_q     <= hit_d;
            healed_q  <= healed_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign calc_start  = (state_q == ST_START);
    assign hp          = hp_q;
    assign dead        = (state_q == ST_DEAD);
    assign invuln      = (ifr_q != '0);
    assign busy        = busy_w;
    assign hit         = hit_q;
    assign healed      = healed_q;
    assign timeout_err = timeout_q;
    assign overrun     = overrun_q;

endmodule

`default_nettype wire
